// File: rtl/apb_spi_regfile.sv
// APB register file for the SPI controller: CTRL/BAUD/SSEL/STATUS/DATA plus RX buffer, overrun and irq.
// Latency: PREADY_o rises on access cycle WAIT_STATES+1; side effects land on the edge closing that cycle.
// Backpressure: the bus is held by PREADY_o=0 during wait states; bad accesses complete with PSLVERR_o.
module apb_spi_regfile #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int NUM_SS      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL_i,
    input  logic              PENABLE_i,
    input  logic              PWRITE_i,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [DATA_W-1:0] PWDATA_i,
    output logic [DATA_W-1:0] PRDATA_o,
    output logic              PREADY_o,
    output logic              PSLVERR_o,
    input  logic              tip_i,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic              spe_o,
    output logic              mstr_o,
    output logic              cpol_o,
    output logic              cpha_o,
    output logic              lsbfe_o,
    output logic [DATA_W-1:0] baud_o,
    output logic [NUM_SS-1:0] ss_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              send_data_o,
    output logic              irq_o
);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_BAUD = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_SSEL = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(4);
    localparam logic [3:0]        WS     = 4'(WAIT_STATES);

    // The APB setup cycle is the IDLE cycle that sees PSEL & !PENABLE; ACCESS follows at once.
    typedef enum logic {S_IDLE, S_ACCESS} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d, err_q, err_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wait_q, wait_d;
    logic [5:0]          ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   baud_q, baud_d, tx_q, tx_d, rx_q, rx_d;
    logic [NUM_SS-1:0]   ssel_q, ssel_d;
    logic                spif_q, spif_d, ovr_q, ovr_d, txe_q, txe_d;
    logic                send_q, send_d, tip_q, tip_d;

    logic                setup, pready, wr_ok, rd_ok, req_err;
    logic [DATA_W-1:0]   rdata;

    always_comb begin
        setup   = PSEL_i & ~PENABLE_i;
        pready  = (state_q == S_ACCESS) && (wait_q == WS);
        wr_ok   = pready & PSEL_i & ~err_q & write_q;
        rd_ok   = pready & PSEL_i & ~err_q & ~write_q;
        req_err = (PADDR_i > A_DATA) |
                  (PWRITE_i & ((PADDR_i == A_STAT) |
                               ((PADDR_i <= A_SSEL) & tip_i) |
                               ((PADDR_i == A_DATA) & (tip_i | ~txe_q))));

        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        wait_d  = wait_q;
        ctrl_d  = ctrl_q;
        baud_d  = baud_q;
        ssel_d  = ssel_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        spif_d  = spif_q;
        ovr_d   = ovr_q;
        txe_d   = txe_q;
        send_d  = 1'b0;
        tip_d   = tip_i;

        if ((state_q == S_ACCESS) && !PSEL_i) begin
            state_d = S_IDLE;
        end else if (setup) begin
            state_d = S_ACCESS;
            addr_d  = PADDR_i;
            write_d = PWRITE_i;
            wdata_d = PWDATA_i;
            err_d   = req_err;
            wait_d  = 4'd0;
        end else if (state_q == S_ACCESS) begin
            if (pready) state_d = S_IDLE;
            else        wait_d  = wait_q + 4'd1;
        end

        if (tip_i & ~tip_q) txe_d = 1'b1;

        if (wr_ok) begin
            case (addr_q)
                A_CTRL:  ctrl_d = wdata_q[5:0];
                A_BAUD:  baud_d = wdata_q;
                A_SSEL:  ssel_d = wdata_q[NUM_SS-1:0];
                A_DATA: begin
                    tx_d   = wdata_q;
                    txe_d  = 1'b0;
                    send_d = 1'b1;
                end
                default: ;
            endcase
        end

        // A word arriving on the same edge as a DATA read keeps spif set and leaves ovr alone.
        if (rx_valid_i) begin
            rx_d   = rx_data_i;
            spif_d = 1'b1;
            if (!(rd_ok && addr_q == A_DATA)) ovr_d = ovr_q | spif_q;
        end else if (rd_ok && addr_q == A_DATA) begin
            spif_d = 1'b0;
            ovr_d  = 1'b0;
        end

        rdata = '0;
        if (pready && !err_q && !write_q) begin
            case (addr_q)
                A_CTRL:  rdata[5:0]        = ctrl_q;
                A_BAUD:  rdata             = baud_q;
                A_SSEL:  rdata[NUM_SS-1:0] = ssel_q;
                A_STAT:  rdata[3:0]        = {ovr_q, txe_q, spif_q, tip_i};
                A_DATA:  rdata             = rx_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= 4'd0;
            ctrl_q  <= '0;
            baud_q  <= '0;
            ssel_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            spif_q  <= 1'b0;
            ovr_q   <= 1'b0;
            txe_q   <= 1'b1;
            send_q  <= 1'b0;
            tip_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
            baud_q  <= baud_d;
            ssel_q  <= ssel_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            spif_q  <= spif_d;
            ovr_q   <= ovr_d;
            txe_q   <= txe_d;
            send_q  <= send_d;
            tip_q   <= tip_d;
        end
    end

    assign PRDATA_o    = rdata;
    assign PREADY_o    = pready;
    assign PSLVERR_o   = pready & err_q;
    assign spe_o       = ctrl_q[0];
    assign mstr_o      = ctrl_q[1];
    assign cpol_o      = ctrl_q[2];
    assign cpha_o      = ctrl_q[3];
    assign lsbfe_o     = ctrl_q[4];
    assign baud_o      = baud_q;
    assign ss_o        = ctrl_q[0] ? ~ssel_q : '1;
    assign tx_data_o   = tx_q;
    assign send_data_o = send_q;
    assign irq_o       = ctrl_q[5] & (spif_q | ovr_q);
endmodule

// File: tb/tb_apb_spi_regfile.sv
// Bench for apb_spi_regfile: directed vector table, hand-written corner sequences and a randomized run
// checked against a register-level model of the programmer-visible state.
module tb_apb_spi_regfile;
    logic       clk, rst;
    logic       psel, penable, pwrite, tip, rx_valid;
    logic [2:0] paddr;
    logic [7:0] pwdata, rx_data;
    logic [7:0] prdata, baud_o, tx_data_o;
    logic       pready, pslverr, spe_o, mstr_o, cpol_o, cpha_o, lsbfe_o, send_data_o, irq_o;
    logic [3:0] ss_o;

    logic        psel2, penable2, pwrite2;
    logic [2:0]  paddr2;
    logic [15:0] pwdata2, prdata2, baud2, tx2;
    logic        pready2, pslverr2, spe2, mstr2, cpol2, cpha2, lsbfe2, send2, irq2;
    logic [3:0]  ss2;
    logic        tip2, rxv2;
    logic [15:0] rxd2;

    int n_cmp = 0;
    int n_bad = 0;

    apb_spi_regfile u_dut (
        .PCLK(clk), .PRESET(rst), .PSEL_i(psel), .PENABLE_i(penable), .PWRITE_i(pwrite),
        .PADDR_i(paddr), .PWDATA_i(pwdata), .PRDATA_o(prdata), .PREADY_o(pready),
        .PSLVERR_o(pslverr), .tip_i(tip), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .spe_o(spe_o), .mstr_o(mstr_o), .cpol_o(cpol_o), .cpha_o(cpha_o), .lsbfe_o(lsbfe_o),
        .baud_o(baud_o), .ss_o(ss_o), .tx_data_o(tx_data_o), .send_data_o(send_data_o),
        .irq_o(irq_o)
    );

    apb_spi_regfile #(.DATA_W(16), .ADDR_W(3), .NUM_SS(4), .WAIT_STATES(3)) u_ws (
        .PCLK(clk), .PRESET(rst), .PSEL_i(psel2), .PENABLE_i(penable2), .PWRITE_i(pwrite2),
        .PADDR_i(paddr2), .PWDATA_i(pwdata2), .PRDATA_o(prdata2), .PREADY_o(pready2),
        .PSLVERR_o(pslverr2), .tip_i(tip2), .rx_valid_i(rxv2), .rx_data_i(rxd2),
        .spe_o(spe2), .mstr_o(mstr2), .cpol_o(cpol2), .cpha_o(cpha2), .lsbfe_o(lsbfe2),
        .baud_o(baud2), .ss_o(ss2), .tx_data_o(tx2), .send_data_o(send2), .irq_o(irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_tip(input logic v);
        @(posedge clk); #1 tip = v;
        @(posedge clk); #1;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = d;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    // One APB transfer; acc_* are driven during the access phase to build same-edge collisions.
    task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                       input logic acc_tip, input logic acc_rx, input logic [7:0] acc_rxd,
                       output logic [7:0] rd, output logic err, output int cyc, output logic snd);
        @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1; tip = acc_tip; rx_valid = acc_rx; rx_data = acc_rxd;
        cyc = 1;
        while (!pready && cyc < 40) begin @(posedge clk); #1; cyc++; end
        if (!pready) check("pready_timeout", {31'd0, pready}, 32'd1);
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
        snd = send_data_o;
    endtask

    task automatic apb2(input logic wr, input logic [2:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic err, output int cyc);
        @(posedge clk); #1 psel2 = 1'b1; penable2 = 1'b0; pwrite2 = wr; paddr2 = a; pwdata2 = d;
        @(posedge clk); #1 penable2 = 1'b1;
        cyc = 1;
        while (!pready2 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        if (!pready2) check("ws_pready_timeout", {31'd0, pready2}, 32'd1);
        rd  = prdata2;
        err = pslverr2;
        @(posedge clk); #1 psel2 = 1'b0; penable2 = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic       tip;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic       exp_snd;
    } vec_t;

    // Register-level model used by the randomized phase.
    logic [5:0] m_ctrl;
    logic [7:0] m_baud, m_tx, m_rx;
    logic [3:0] m_ssel;
    logic       m_spif, m_ovr, m_txe, m_tip;

    initial begin
        vec_t        vecs[14];
        logic [7:0]  rd, d, exp_rd;
        logic [15:0] rd2;
        logic        err, snd, wr, e, nt;
        logic [2:0]  a;
        logic [3:0]  m_ss;
        int          cyc;

        vecs[0]  = '{1'b1, 3'd0, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd6, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 3'd1, 8'h22, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 3'd2, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'd2, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd3, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'd3, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'd5, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 3'd4, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 3'd4, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 3'd0, 8'h23, 1'b0, 8'h00, 1'b0, 1'b0};

        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; tip = 0; rx_valid = 0; rx_data = 0;
        psel2 = 0; penable2 = 0; pwrite2 = 0; paddr2 = 0; pwdata2 = 0; tip2 = 0; rxv2 = 0; rxd2 = 0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        check("reset_pready", {31'd0, pready}, 32'd0);
        check("reset_pslverr", {31'd0, pslverr}, 32'd0);
        check("reset_ss", {28'd0, ss_o}, 32'hF);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("reset_status", {24'd0, rd}, 32'h04);

        for (int i = 0; i < 14; i++) begin
            if (tip !== vecs[i].tip) set_tip(vecs[i].tip);
            apb(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].tip, 1'b0, 8'h00, rd, err, cyc, snd);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d_latency", i), cyc, 32'd1);
            check($sformatf("vec%0d_send", i), {31'd0, snd}, {31'd0, vecs[i].exp_snd});
        end
        check("ss_after_ssel", {28'd0, ss_o}, 32'hE);
        check("spe_mstr", {30'd0, mstr_o, spe_o}, 32'h3);
        check("tx_data", {24'd0, tx_data_o}, 32'h5A);
        check("baud_unchanged", {24'd0, baud_o}, 32'h00);
        check("send_idle", {31'd0, send_data_o}, 32'd0);

        rx_pulse(8'hC3);
        check("irq_on_rx", {31'd0, irq_o}, 32'd1);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("status_spif", {24'd0, rd}, 32'h02);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("rx_read", {24'd0, rd}, 32'hC3);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("status_cleared", {24'd0, rd}, 32'h00);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);

        set_tip(1'b1);
        set_tip(1'b0);
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("status_overrun", {24'd0, rd}, 32'h0E);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("overrun_word", {24'd0, rd}, 32'h22);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("status_after_ovr_read", {24'd0, rd}, 32'h04);

        rx_pulse(8'h33);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 1'b1, 8'h44, rd, err, cyc, snd);
        check("collide_old_word", {24'd0, rd}, 32'h33);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("collide_status", {24'd0, rd}, 32'h06);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, rd, err, cyc, snd);
        check("collide_new_word", {24'd0, rd}, 32'h44);

        apb(1'b1, 3'd4, 8'h77, 1'b1, 1'b0, 8'h00, rd, err, cyc, snd);
        check("tipwr_err", {31'd0, err}, 32'd0);
        check("tipwr_send", {31'd0, snd}, 32'd1);
        apb(1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 8'h00, rd, err, cyc, snd);
        check("tipwr_status", {24'd0, rd}, 32'h01);
        set_tip(1'b0);

        @(posedge clk); #1 psel = 1'b1; penable = 1'b1;
        idle(2);
        check("penable_in_idle", {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;

        @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'h99;
        @(posedge clk); #1 psel = 1'b0;
        idle(2);
        check("abort_no_write", {24'd0, baud_o}, 32'h00);

        apb2(1'b1, 3'd1, 16'hA55A, rd2, err, cyc);
        check("ws_write_latency", cyc, 32'd4);
        check("ws_write_err", {31'd0, err}, 32'd0);
        apb2(1'b0, 3'd1, 16'h0000, rd2, err, cyc);
        check("ws_read_latency", cyc, 32'd4);
        check("ws_read_data", {16'd0, rd2}, 32'hA55A);
        check("ws_baud_o", {16'd0, baud2}, 32'hA55A);

        rst = 1'b1; tip = 1'b0;
        idle(2);
        rst = 1'b0;
        m_ctrl = 0; m_baud = 0; m_ssel = 0; m_tx = 0; m_rx = 0;
        m_spif = 0; m_ovr = 0; m_txe = 1; m_tip = 0;

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                nt = ~m_tip;
                set_tip(nt);
                if (nt) m_txe = 1'b1;
                m_tip = nt;
            end
            if ($urandom_range(0, 2) == 0) begin
                d = 8'($urandom);
                rx_pulse(d);
                if (m_spif) m_ovr = 1'b1;
                m_spif = 1'b1;
                m_rx   = d;
            end
            wr = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            e  = (a > 3'd4) || (wr && (a == 3'd3 || (a < 3'd3 && m_tip) || (a == 3'd4 && (m_tip || !m_txe))));
            exp_rd = 8'h00;
            if (!e) begin
                case (a)
                    3'd0: exp_rd = {2'b00, m_ctrl};
                    3'd1: exp_rd = m_baud;
                    3'd2: exp_rd = {4'h0, m_ssel};
                    3'd3: exp_rd = {4'h0, m_ovr, m_txe, m_spif, m_tip};
                    3'd4: exp_rd = m_rx;
                    default: exp_rd = 8'h00;
                endcase
            end
            apb(wr, a, d, m_tip, 1'b0, 8'h00, rd, err, cyc, snd);
            check($sformatf("rnd%0d_err", it), {31'd0, err}, {31'd0, e});
            if (!wr) check($sformatf("rnd%0d_rdata", it), {24'd0, rd}, {24'd0, exp_rd});
            check($sformatf("rnd%0d_send", it), {31'd0, snd}, {31'd0, !e && wr && a == 3'd4});
            if (!e && wr) begin
                case (a)
                    3'd0: m_ctrl = d[5:0];
                    3'd1: m_baud = d;
                    3'd2: m_ssel = d[3:0];
                    3'd4: begin m_tx = d; m_txe = 1'b0; end
                    default: ;
                endcase
            end
            if (!e && !wr && a == 3'd4) begin m_spif = 1'b0; m_ovr = 1'b0; end
            m_ss = m_ctrl[0] ? ~m_ssel : 4'hF;
            check($sformatf("rnd%0d_outs", it),
                  {6'd0, irq_o, tx_data_o, ss_o, baud_o, lsbfe_o, cpha_o, cpol_o, mstr_o, spe_o},
                  {6'd0, m_ctrl[5] & (m_spif | m_ovr), m_tx, m_ss, m_baud, m_ctrl[4:0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
